// File: rtl/lsu_mem.sv
// Memory-stage load/store unit: turns the registered memory-stage command into a
// data-memory req/ack transaction and registers the write-back result.
module lsu_mem (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] result_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        ld_i,
    input  logic        we_mem_i,
    input  logic [2:0]  sx_ctrl_i,
    input  logic [4:0]  rd_i,
    input  logic        we_reg_i,
    output logic        dm_req_o,
    output logic        dm_we_o,
    output logic [31:0] dm_addr_o,
    output logic [3:0]  dm_be_o,
    output logic [31:0] dm_wdata_o,
    input  logic        dm_ack_i,
    input  logic [31:0] dm_rdata_i,
    output logic        stall_o,
    output logic [31:0] wb_data_o,
    output logic [4:0]  wb_rd_o,
    output logic        wb_we_o,
    output logic        misalign_o
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned BEW  = 4;
    localparam int unsigned RW   = 5;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic            dm_req_q,   dm_req_d;
    logic            dm_we_q,    dm_we_d;
    logic [XLEN-1:0] dm_addr_q,  dm_addr_d;
    logic [BEW-1:0]  dm_be_q,    dm_be_d;
    logic [XLEN-1:0] dm_wdata_q, dm_wdata_d;
    logic [1:0]      lane_q,     lane_d;
    logic [1:0]      size_q,     size_d;
    logic            zext_q,     zext_d;
    logic [RW-1:0]   rd_q,       rd_d;
    logic            we_reg_q,   we_reg_d;
    logic [XLEN-1:0] result_q,   result_d;
    logic [XLEN-1:0] wb_data_q,  wb_data_d;
    logic [RW-1:0]   wb_rd_q,    wb_rd_d;
    logic            wb_we_q,    wb_we_d;
    logic            misalign_q, misalign_d;
    logic            stall_c;

    // Command decode of the incoming memory-stage instruction
    logic            mem_op_c;
    logic            misal_c;
    logic            req_go_c;
    logic [1:0]      size_c;
    logic [BEW-1:0]  be_c;
    logic [XLEN-1:0] wdata_c;

    assign size_c   = sx_ctrl_i[1:0];
    assign mem_op_c = ld_i | we_mem_i;
    assign misal_c  = mem_op_c &
                      (((size_c == SZ_HALF) & addr_i[0]) |
                       (size_c[1] & (addr_i[1:0] != 2'b00)));
    assign req_go_c = mem_op_c & ~misal_c;

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = wdata_i;
        case (size_c)
            SZ_BYTE: begin
                be_c    = BEW'(4'b0001 << addr_i[1:0]);
                wdata_c = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                be_c    = BEW'(4'b0011 << {addr_i[1], 1'b0});
                wdata_c = {2{wdata_i[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = wdata_i;
            end
        endcase
    end

    // Lane select and extension of the returned read word
    logic [7:0]      ld_byte_c;
    logic [15:0]     ld_half_c;
    logic [XLEN-1:0] ld_fmt_c;

    always_comb begin
        case (lane_q)
            2'd0:    ld_byte_c = dm_rdata_i[7:0];
            2'd1:    ld_byte_c = dm_rdata_i[15:8];
            2'd2:    ld_byte_c = dm_rdata_i[23:16];
            default: ld_byte_c = dm_rdata_i[31:24];
        endcase
        ld_half_c = lane_q[1] ? dm_rdata_i[31:16] : dm_rdata_i[15:0];
        case (size_q)
            SZ_BYTE: ld_fmt_c = zext_q ? {24'd0, ld_byte_c}
                                       : {{24{ld_byte_c[7]}}, ld_byte_c};
            SZ_HALF: ld_fmt_c = zext_q ? {16'd0, ld_half_c}
                                       : {{16{ld_half_c[15]}}, ld_half_c};
            default: ld_fmt_c = dm_rdata_i;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_go_c) state_d = BUSY;
            BUSY:    if (dm_ack_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: next values of the bus and write-back registers, plus stall
    always_comb begin
        dm_req_d   = dm_req_q;
        dm_we_d    = dm_we_q;
        dm_addr_d  = dm_addr_q;
        dm_be_d    = dm_be_q;
        dm_wdata_d = dm_wdata_q;
        lane_d     = lane_q;
        size_d     = size_q;
        zext_d     = zext_q;
        rd_d       = rd_q;
        we_reg_d   = we_reg_q;
        result_d   = result_q;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_we_d    = 1'b0;
        misalign_d = 1'b0;
        stall_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_go_c) begin
                    dm_req_d   = 1'b1;
                    dm_we_d    = we_mem_i;
                    dm_addr_d  = {addr_i[31:2], 2'b00};
                    dm_be_d    = be_c;
                    dm_wdata_d = wdata_c;
                    lane_d     = addr_i[1:0];
                    size_d     = size_c;
                    zext_d     = sx_ctrl_i[2];
                    rd_d       = rd_i;
                    we_reg_d   = we_reg_i;
                    result_d   = result_i;
                    stall_c    = 1'b1;
                end else if (misal_c) begin
                    misalign_d = 1'b1;
                end else begin
                    wb_data_d = result_i;
                    wb_rd_d   = rd_i;
                    wb_we_d   = we_reg_i;
                end
            end
            BUSY: begin
                if (dm_ack_i) begin
                    dm_req_d  = 1'b0;
                    wb_data_d = dm_we_q ? result_q : ld_fmt_c;
                    wb_rd_d   = rd_q;
                    wb_we_d   = we_reg_q;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Bus request and write-back registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_be_q    <= '0;
            dm_wdata_q <= '0;
            lane_q     <= '0;
            size_q     <= '0;
            zext_q     <= 1'b0;
            rd_q       <= '0;
            we_reg_q   <= 1'b0;
            result_q   <= '0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_we_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            dm_req_q   <= dm_req_d;
            dm_we_q    <= dm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_be_q    <= dm_be_d;
            dm_wdata_q <= dm_wdata_d;
            lane_q     <= lane_d;
            size_q     <= size_d;
            zext_q     <= zext_d;
            rd_q       <= rd_d;
            we_reg_q   <= we_reg_d;
            result_q   <= result_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_we_q    <= wb_we_d;
            misalign_q <= misalign_d;
        end
    end

    // Stall is forced low while reset is asserted
    assign stall_o    = rst_n & stall_c;
    assign dm_req_o   = dm_req_q;
    assign dm_we_o    = dm_we_q;
    assign dm_addr_o  = dm_addr_q;
    assign dm_be_o    = dm_be_q;
    assign dm_wdata_o = dm_wdata_q;
    assign wb_data_o  = wb_data_q;
    assign wb_rd_o    = wb_rd_q;
    assign wb_we_o    = wb_we_q;
    assign misalign_o = misalign_q;

endmodule

// File: tb/tb_lsu_mem.sv
// Directed bench for lsu_mem: each task drives one scenario and checks the
// bus, stall and write-back outputs against hand-computed values.
module tb_lsu_mem;

    logic        clk;
    logic        rst_n;
    logic [31:0] result_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ld_i;
    logic        we_mem_i;
    logic [2:0]  sx_ctrl_i;
    logic [4:0]  rd_i;
    logic        we_reg_i;
    logic        dm_req_o;
    logic        dm_we_o;
    logic [31:0] dm_addr_o;
    logic [3:0]  dm_be_o;
    logic [31:0] dm_wdata_o;
    logic        dm_ack_i;
    logic [31:0] dm_rdata_i;
    logic        stall_o;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_rd_o;
    logic        wb_we_o;
    logic        misalign_o;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_mem dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .result_i   (result_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .ld_i       (ld_i),
        .we_mem_i   (we_mem_i),
        .sx_ctrl_i  (sx_ctrl_i),
        .rd_i       (rd_i),
        .we_reg_i   (we_reg_i),
        .dm_req_o   (dm_req_o),
        .dm_we_o    (dm_we_o),
        .dm_addr_o  (dm_addr_o),
        .dm_be_o    (dm_be_o),
        .dm_wdata_o (dm_wdata_o),
        .dm_ack_i   (dm_ack_i),
        .dm_rdata_i (dm_rdata_i),
        .stall_o    (stall_o),
        .wb_data_o  (wb_data_o),
        .wb_rd_o    (wb_rd_o),
        .wb_we_o    (wb_we_o),
        .misalign_o (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nop;
        ld_i      = 1'b0;
        we_mem_i  = 1'b0;
        we_reg_i  = 1'b0;
        result_i  = 32'h0;
        addr_i    = 32'h0;
        wdata_i   = 32'h0;
        sx_ctrl_i = 3'b010;
        rd_i      = 5'd0;
    endtask

    task automatic drive_op(input logic ld, input logic st, input logic [31:0] addr,
                            input logic [2:0] sx, input logic [4:0] rd, input logic wer);
        ld_i      = ld;
        we_mem_i  = st;
        addr_i    = addr;
        sx_ctrl_i = sx;
        rd_i      = rd;
        we_reg_i  = wer;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        dm_ack_i = 1'b0;
        dm_rdata_i = 32'h0;
        drive_nop();
        drive_op(1'b1, 1'b0, 32'h100, 3'b010, 5'd3, 1'b1);
        tick();
        tick();
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b expected 0", stall_o); end
        n_checks++; if (dm_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", dm_req_o); end
        n_checks++; if ({dm_we_o, dm_addr_o, dm_be_o, dm_wdata_o} !== 69'd0) begin n_fail++; $display("FAIL rst_bus: we %b addr %h be %b wdata %h expected all 0", dm_we_o, dm_addr_o, dm_be_o, dm_wdata_o); end
        n_checks++; if ({wb_data_o, wb_rd_o, wb_we_o, misalign_o} !== 39'd0) begin n_fail++; $display("FAIL rst_wb: data %h rd %0d we %b mis %b expected all 0", wb_data_o, wb_rd_o, wb_we_o, misalign_o); end
        drive_nop();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_word_load;
        drive_op(1'b1, 1'b0, 32'h100, 3'b010, 5'd3, 1'b1);
        #1;
        n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL wl_stall_c0: got %b expected 1", stall_o); end
        tick();
        n_checks++; if (dm_req_o !== 1'b1 || dm_we_o !== 1'b0) begin n_fail++; $display("FAIL wl_req: req %b we %b expected 1 0", dm_req_o, dm_we_o); end
        n_checks++; if (dm_addr_o !== 32'h100 || dm_be_o !== 4'b1111) begin n_fail++; $display("FAIL wl_addr_be: addr %h be %b expected 100 1111", dm_addr_o, dm_be_o); end
        dm_ack_i = 1'b1;
        dm_rdata_i = 32'h8000_00FF;
        #1;
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL wl_stall_ack: got %b expected 0", stall_o); end
        tick();
        dm_ack_i = 1'b0;
        drive_nop();
        n_checks++; if (wb_data_o !== 32'h8000_00FF) begin n_fail++; $display("FAIL wl_wbdata: got %h expected 800000ff", wb_data_o); end
        n_checks++; if (wb_we_o !== 1'b1 || wb_rd_o !== 5'd3) begin n_fail++; $display("FAIL wl_wbwe_rd: we %b rd %0d expected 1 3", wb_we_o, wb_rd_o); end
        n_checks++; if (dm_req_o !== 1'b0) begin n_fail++; $display("FAIL wl_req_drop: got %b expected 0", dm_req_o); end
        tick();
    endtask

    task automatic test_byte_load_signed;
        drive_op(1'b1, 1'b0, 32'h203, 3'b000, 5'd7, 1'b1);
        #1;
        n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL bs_stall_c0: got %b expected 1", stall_o); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++; if (stall_o !== 1'b1 || dm_req_o !== 1'b1) begin n_fail++; $display("FAIL bs_wait%0d: stall %b req %b expected 1 1", i, stall_o, dm_req_o); end
            n_checks++; if (dm_be_o !== 4'b1000 || dm_addr_o !== 32'h200) begin n_fail++; $display("FAIL bs_be%0d: be %b addr %h expected 1000 200", i, dm_be_o, dm_addr_o); end
            n_checks++; if (wb_we_o !== 1'b0) begin n_fail++; $display("FAIL bs_bubble%0d: wb_we %b expected 0", i, wb_we_o); end
        end
        tick();
        dm_ack_i = 1'b1;
        dm_rdata_i = 32'h8012_3456;
        #1;
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL bs_stall_ack: got %b expected 0", stall_o); end
        tick();
        dm_ack_i = 1'b0;
        drive_nop();
        n_checks++; if (wb_data_o !== 32'hFFFF_FF80 || wb_rd_o !== 5'd7 || wb_we_o !== 1'b1) begin n_fail++; $display("FAIL bs_wb: data %h rd %0d we %b expected ffffff80 7 1", wb_data_o, wb_rd_o, wb_we_o); end
        tick();
    endtask

    task automatic test_zext_then_alu;
        drive_op(1'b1, 1'b0, 32'h203, 3'b100, 5'd9, 1'b1);
        tick();
        dm_ack_i = 1'b1;
        dm_rdata_i = 32'h80AB_CDEF;
        #1;
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL bz_stall_ack: got %b expected 0", stall_o); end
        tick();
        dm_ack_i = 1'b0;
        drive_op(1'b0, 1'b0, 32'h0, 3'b010, 5'd5, 1'b1);
        result_i = 32'hDEAD_BEEF;
        n_checks++; if (wb_data_o !== 32'h0000_0080 || wb_rd_o !== 5'd9 || wb_we_o !== 1'b1) begin n_fail++; $display("FAIL bz_wb: data %h rd %0d we %b expected 00000080 9 1", wb_data_o, wb_rd_o, wb_we_o); end
        #1;
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b expected 0", stall_o); end
        tick();
        drive_nop();
        n_checks++; if (wb_data_o !== 32'hDEAD_BEEF || wb_rd_o !== 5'd5 || wb_we_o !== 1'b1) begin n_fail++; $display("FAIL alu_wb: data %h rd %0d we %b expected deadbeef 5 1", wb_data_o, wb_rd_o, wb_we_o); end
        tick();
    endtask

    task automatic test_half_store;
        drive_op(1'b0, 1'b1, 32'h302, 3'b001, 5'd0, 1'b0);
        wdata_i  = 32'h1234_ABCD;
        result_i = 32'h0000_0302;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++; if (dm_req_o !== 1'b1 || dm_we_o !== 1'b1 || dm_be_o !== 4'b1100) begin n_fail++; $display("FAIL hs_ctl%0d: req %b we %b be %b expected 1 1 1100", i, dm_req_o, dm_we_o, dm_be_o); end
            n_checks++; if (dm_wdata_o !== 32'hABCD_ABCD || dm_addr_o !== 32'h300) begin n_fail++; $display("FAIL hs_data%0d: wdata %h addr %h expected abcdabcd 300", i, dm_wdata_o, dm_addr_o); end
            n_checks++; if (wb_we_o !== 1'b0) begin n_fail++; $display("FAIL hs_wbwe%0d: got %b expected 0", i, wb_we_o); end
        end
        dm_ack_i = 1'b1;
        #1;
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL hs_stall_ack: got %b expected 0", stall_o); end
        tick();
        dm_ack_i = 1'b0;
        drive_nop();
        n_checks++; if (dm_req_o !== 1'b0 || wb_we_o !== 1'b0 || wb_data_o !== 32'h302) begin n_fail++; $display("FAIL hs_done: req %b wb_we %b wb_data %h expected 0 0 302", dm_req_o, wb_we_o, wb_data_o); end
        tick();
    endtask

    task automatic test_misaligned;
        drive_op(1'b1, 1'b0, 32'h101, 3'b010, 5'd4, 1'b1);
        #1;
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL mis_stall: got %b expected 0", stall_o); end
        tick();
        drive_op(1'b0, 1'b1, 32'h303, 3'b001, 5'd0, 1'b0);
        n_checks++; if (misalign_o !== 1'b1 || dm_req_o !== 1'b0 || wb_we_o !== 1'b0) begin n_fail++; $display("FAIL mis_pulse: mis %b req %b wb_we %b expected 1 0 0", misalign_o, dm_req_o, wb_we_o); end
        #1;
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL mis_half_stall: got %b expected 0", stall_o); end
        tick();
        drive_nop();
        n_checks++; if (misalign_o !== 1'b1 || dm_req_o !== 1'b0) begin n_fail++; $display("FAIL mis_half: mis %b req %b expected 1 0", misalign_o, dm_req_o); end
        tick();
        n_checks++; if (misalign_o !== 1'b0 || dm_req_o !== 1'b0) begin n_fail++; $display("FAIL mis_end: mis %b req %b expected 0 0", misalign_o, dm_req_o); end
    endtask

    task automatic test_back_to_back;
        drive_op(1'b1, 1'b0, 32'h500, 3'b010, 5'd1, 1'b1);
        tick();
        dm_ack_i = 1'b1;
        dm_rdata_i = 32'h1111_1111;
        tick();
        dm_ack_i = 1'b0;
        drive_op(1'b1, 1'b0, 32'h504, 3'b010, 5'd2, 1'b1);
        n_checks++; if (dm_req_o !== 1'b0 || wb_data_o !== 32'h1111_1111) begin n_fail++; $display("FAIL b2b_gap: req %b wb_data %h expected 0 11111111", dm_req_o, wb_data_o); end
        #1;
        n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL b2b_stall2: got %b expected 1", stall_o); end
        tick();
        n_checks++; if (dm_req_o !== 1'b1 || dm_addr_o !== 32'h504) begin n_fail++; $display("FAIL b2b_req2: req %b addr %h expected 1 504", dm_req_o, dm_addr_o); end
        dm_ack_i = 1'b1;
        dm_rdata_i = 32'h2222_2222;
        tick();
        dm_ack_i = 1'b0;
        drive_nop();
        n_checks++; if (wb_data_o !== 32'h2222_2222 || wb_rd_o !== 5'd2 || wb_we_o !== 1'b1) begin n_fail++; $display("FAIL b2b_wb2: data %h rd %0d we %b expected 22222222 2 1", wb_data_o, wb_rd_o, wb_we_o); end
        tick();
    endtask

    task automatic test_reset_mid_busy;
        drive_op(1'b1, 1'b0, 32'h600, 3'b010, 5'd6, 1'b1);
        tick();
        n_checks++; if (dm_req_o !== 1'b1) begin n_fail++; $display("FAIL rb_req: got %b expected 1", dm_req_o); end
        rst_n = 1'b0;
        drive_nop();
        #1;
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL rb_stall_rst: got %b expected 0", stall_o); end
        tick();
        rst_n = 1'b1;
        dm_ack_i = 1'b1;
        dm_rdata_i = 32'hCAFE_F00D;
        n_checks++; if (dm_req_o !== 1'b0 || dm_addr_o !== 32'h0 || dm_be_o !== 4'b0000 || wb_we_o !== 1'b0) begin n_fail++; $display("FAIL rb_cleared: req %b addr %h be %b wb_we %b expected 0 0 0 0", dm_req_o, dm_addr_o, dm_be_o, wb_we_o); end
        #1;
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL rb_late_stall: got %b expected 0", stall_o); end
        tick();
        dm_ack_i = 1'b0;
        n_checks++; if (wb_we_o !== 1'b0 || wb_data_o !== 32'h0 || dm_req_o !== 1'b0) begin n_fail++; $display("FAIL rb_late_ack: wb_we %b wb_data %h req %b expected 0 0 0", wb_we_o, wb_data_o, dm_req_o); end
        tick();
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_load_signed();
        test_zext_then_alu();
        test_half_store();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
